credit_link_tx: RTL and testbench



---
 rtl/noc_link_pkg.sv | 20 ++
 rtl/credit_link_tx_if.sv | 37 +++
 rtl/flit_skid_fifo2.sv | 67 ++++++
 rtl/credit_link_tx.sv | 118 +++++++++++
 tb/tb_credit_link_tx.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the router credit link.
package noc_link_pkg;

  localparam int unsigned FlitWidthDef = 128;
  localparam int unsigned DestWidthDef = 6;

  typedef enum logic [0:0] {IDLE, BODY} link_state_e;

  // Default-width flit; modules with other widths build a layout-identical struct locally.
  typedef struct packed {
    logic [FlitWidthDef-1:0] data;
    logic [DestWidthDef-1:0] dest;
    logic                    is_tail;
  } flit_s;

  function automatic int unsigned credit_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_link_tx_if.sv
// Source-side handshake plus link-side outputs of credit_link_tx.
interface credit_link_tx_if #(
  parameter int unsigned FLIT_WIDTH        = 128,
  parameter int unsigned DEST_WIDTH        = 6,
  parameter int unsigned FLIT_BUFFER_DEPTH = 8
);
  import noc_link_pkg::*;

  localparam int unsigned CredWidth = credit_width(FLIT_BUFFER_DEPTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] in_data;
  logic [DEST_WIDTH-1:0] in_dest;
  logic                  in_is_tail;
  logic [FLIT_WIDTH-1:0] data_out;
  logic [DEST_WIDTH-1:0] dest_out;
  logic                  is_tail_out;
  logic                  send_out;
  logic                  credit_in;
  logic [CredWidth-1:0]  credits_avail;
  logic                  link_idle;
  logic                  credit_err;

  modport master (
    input  in_valid, in_data, in_dest, in_is_tail, credit_in,
    output in_ready, data_out, dest_out, is_tail_out, send_out, credits_avail, link_idle,
           credit_err
  );

  modport slave (
    output in_valid, in_data, in_dest, in_is_tail, credit_in,
    input  in_ready, data_out, dest_out, is_tail_out, send_out, credits_avail, link_idle,
           credit_err
  );

endinterface

// File: rtl/flit_skid_fifo2.sv
// Two-entry flit FIFO with registered full/empty so in_ready never depends on inputs.
module flit_skid_fifo2 #(
  parameter int unsigned Width = 135
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [1:0][Width-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == 2'd2);
    empty_d = (count_d == 2'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/credit_link_tx.sv
// Transmit end of a router credit link: input FIFO, credit counter and packet tracker.
module credit_link_tx
  import noc_link_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH        = FlitWidthDef,
  parameter int unsigned DEST_WIDTH        = DestWidthDef,
  parameter int unsigned FLIT_BUFFER_DEPTH = 8,
  parameter bit          HOLD_HEAD_DEST    = 1'b1
) (
  input logic             clk_noc,
  input logic             rst_noc_sync,
  credit_link_tx_if.master link
);

  localparam int unsigned          CredWidth = credit_width(FLIT_BUFFER_DEPTH);
  localparam logic [CredWidth-1:0] CredMax   = CredWidth'(FLIT_BUFFER_DEPTH);
  localparam logic [CredWidth-1:0] CredOne   = CredWidth'(1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  flit_t                 in_flit, head_flit, out_q, out_d;
  logic                  fifo_full, fifo_empty, fire;
  link_state_e           state_q, state_d;
  logic [DEST_WIDTH-1:0] head_dest_q, head_dest_d;
  logic [CredWidth-1:0]  credits_q, credits_d;
  logic                  credit_err_q, credit_err_d, send_q, send_d;

  assign in_flit = '{data: link.in_data, dest: link.in_dest, is_tail: link.in_is_tail};

  flit_skid_fifo2 #(
    .Width ($bits(flit_t))
  ) u_fifo (
    .clk_i   (clk_noc),
    .rst_i   (rst_noc_sync),
    .push_i  (link.in_valid),
    .wdata_i (in_flit),
    .pop_i   (fire),
    .rdata_o (head_flit),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Registered credits only: a credit returned this cycle cannot enable a send this cycle.
  assign fire = !fifo_empty && (credits_q != '0);

  always_comb begin
    state_d      = state_q;
    head_dest_d  = head_dest_q;
    out_d        = out_q;
    send_d       = 1'b0;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;

    if (fire) begin
      send_d = 1'b1;
      out_d  = head_flit;
      if (HOLD_HEAD_DEST && (state_q == BODY)) begin
        out_d.dest = head_dest_q;
      end
      case (state_q)
        IDLE: begin
          if (!head_flit.is_tail) begin
            state_d     = BODY;
            head_dest_d = head_flit.dest;
          end
        end
        BODY: begin
          if (head_flit.is_tail) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (fire && !link.credit_in) begin
      credits_d = credits_q - CredOne;
    end else if (!fire && link.credit_in) begin
      if (credits_q == CredMax) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CredOne;
      end
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q      <= IDLE;
      head_dest_q  <= '0;
      out_q        <= '0;
      send_q       <= 1'b0;
      credits_q    <= CredMax;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_dest_q  <= head_dest_d;
      out_q        <= out_d;
      send_q       <= send_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign link.in_ready      = !fifo_full;
  assign link.data_out      = out_q.data;
  assign link.dest_out      = out_q.dest;
  assign link.is_tail_out   = out_q.is_tail;
  assign link.send_out      = send_q;
  assign link.credits_avail = credits_q;
  assign link.credit_err    = credit_err_q;
  assign link.link_idle     = fifo_empty && (state_q == IDLE) && (credits_q == CredMax);

endmodule

// File: tb/tb_credit_link_tx.sv
// Self-checking bench for credit_link_tx: directed table, corner sequences, random vs. queue model.
module tb_credit_link_tx;
  import noc_link_pkg::*;

  localparam int unsigned FW    = 128;
  localparam int unsigned DW    = 6;
  localparam int          Depth = 8;
  localparam int unsigned CW    = credit_width(Depth);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  credit_link_tx_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(Depth)) link ();

  credit_link_tx #(
    .FLIT_WIDTH        (FW),
    .DEST_WIDTH        (DW),
    .FLIT_BUFFER_DEPTH (Depth),
    .HOLD_HEAD_DEST    (1'b1)
  ) dut (
    .clk_noc      (clk),
    .rst_noc_sync (rst),
    .link         (link)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted flits and an integer credit budget.
  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } mflit_t;

  mflit_t        mq[$];
  mflit_t        m_f;
  int            m_cred = Depth;
  int            m_sz;
  bit            m_fire, m_send, m_err, m_open, m_tail;
  logic [DW-1:0] m_head, m_dest;
  logic [FW-1:0] m_data;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cred = Depth;
      m_err  = 1'b0;
      m_open = 1'b0;
      m_send = 1'b0;
      m_data = '0;
      m_dest = '0;
      m_tail = 1'b0;
      m_head = '0;
    end else begin
      m_sz   = mq.size();
      m_fire = (m_sz > 0) && (m_cred > 0);
      m_send = m_fire;
      if (m_fire) begin
        m_f    = mq.pop_front();
        m_data = m_f.data;
        m_tail = m_f.tail;
        m_dest = m_open ? m_head : m_f.dest;
        if (!m_open && !m_f.tail) begin
          m_open = 1'b1;
          m_head = m_f.dest;
        end else if (m_open && m_f.tail) begin
          m_open = 1'b0;
        end
      end
      if (link.in_valid && (m_sz < 2)) mq.push_back('{link.in_data, link.in_dest, link.in_is_tail});
      m_cred = m_cred - int'(m_fire) + int'(link.credit_in);
      if (m_cred > Depth) begin
        m_cred = Depth;
        m_err  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model send_out", 128'(link.send_out), 128'(m_send));
      chk("model data_out", 128'(link.data_out), 128'(m_data));
      chk("model dest_out", 128'(link.dest_out), 128'(m_dest));
      chk("model is_tail_out", 128'(link.is_tail_out), 128'(m_tail));
      chk("model credits_avail", 128'(link.credits_avail), 128'(m_cred));
      chk("model in_ready", 128'(link.in_ready), 128'(mq.size() < 2));
      chk("model link_idle", 128'(link.link_idle), 128'(mq.size() == 0 && !m_open && m_cred == Depth));
      chk("model credit_err", 128'(link.credit_err), 128'(m_err));
    end
  end

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic [5:0] dest;
    bit         tail;
    bit         cr;
    bit         e_send;
    logic [7:0] e_data;
    logic [5:0] e_dest;
    bit         e_tail;
    int         e_cred;
    bit         e_ready;
    bit         e_idle;
    bit         e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input logic [7:0] d, input logic [5:0] dest, input bit tail,
                     input bit cr, input bit es, input logic [7:0] ed, input logic [5:0] edst,
                     input bit et, input int ec, input bit er, input bit ei, input bit ee);
    tbl.push_back('{v, d, dest, tail, cr, es, ed, edst, et, ec, er, ei, ee});
  endtask

  task automatic drive(input bit v, input logic [FW-1:0] d, input logic [DW-1:0] dest,
                       input bit tail, input bit cr);
    link.in_valid   = v;
    link.in_data    = d;
    link.in_dest    = dest;
    link.in_is_tail = tail;
    link.credit_in  = cr;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int acc, sends;
  bit hs;

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset send_out", 128'(link.send_out), 128'(0));
    chk("reset data_out", 128'(link.data_out), 128'(0));
    chk("reset dest_out", 128'(link.dest_out), 128'(0));
    chk("reset is_tail_out", 128'(link.is_tail_out), 128'(0));
    chk("reset credits", 128'(link.credits_avail), 128'(Depth));
    chk("reset credit_err", 128'(link.credit_err), 128'(0));
    chk("reset in_ready", 128'(link.in_ready), 128'(1));
    chk("reset link_idle", 128'(link.link_idle), 128'(1));
    rst    = 1'b0;
    chk_en = 1'b1;

    //   v  data   dest  tl cr | send data  dest  tail cred rdy idle err
    add(1, 8'hA5, 6'h0B, 1, 0,   0, 8'h00, 6'h00, 0,   8,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 0,   1, 8'hA5, 6'h0B, 1,   7,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 0,   0, 8'h00, 6'h00, 0,   7,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 1,   0, 8'h00, 6'h00, 0,   8,   1,  1,   0);
    add(0, 8'h00, 6'h00, 0, 0,   0, 8'h00, 6'h00, 0,   8,   1,  1,   0);
    add(1, 8'h01, 6'd3,  0, 0,   0, 8'h00, 6'h00, 0,   8,   1,  0,   0);
    add(1, 8'h02, 6'd9,  0, 0,   1, 8'h01, 6'd3,  0,   7,   1,  0,   0);
    add(1, 8'h03, 6'd9,  0, 0,   1, 8'h02, 6'd3,  0,   6,   1,  0,   0);
    add(1, 8'h04, 6'd9,  1, 0,   1, 8'h03, 6'd3,  0,   5,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 0,   1, 8'h04, 6'd3,  1,   4,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 1,   0, 8'h00, 6'h00, 0,   5,   1,  0,   0);
    add(1, 8'h05, 6'd9,  1, 1,   0, 8'h00, 6'h00, 0,   6,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 1,   1, 8'h05, 6'd9,  1,   6,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 1,   0, 8'h00, 6'h00, 0,   7,   1,  0,   0);
    add(0, 8'h00, 6'h00, 0, 1,   0, 8'h00, 6'h00, 0,   8,   1,  1,   0);
    add(0, 8'h00, 6'h00, 0, 1,   0, 8'h00, 6'h00, 0,   8,   1,  1,   1);
    add(0, 8'h00, 6'h00, 0, 0,   0, 8'h00, 6'h00, 0,   8,   1,  1,   1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, FW'(tbl[i].d), tbl[i].dest, tbl[i].tail, tbl[i].cr);
      @(negedge clk);
      chk($sformatf("tbl[%0d] send_out", i), 128'(link.send_out), 128'(tbl[i].e_send));
      if (tbl[i].e_send) begin
        chk($sformatf("tbl[%0d] data_out", i), 128'(link.data_out), 128'(tbl[i].e_data));
        chk($sformatf("tbl[%0d] dest_out", i), 128'(link.dest_out), 128'(tbl[i].e_dest));
        chk($sformatf("tbl[%0d] is_tail_out", i), 128'(link.is_tail_out), 128'(tbl[i].e_tail));
      end
      chk($sformatf("tbl[%0d] credits", i), 128'(link.credits_avail), 128'(tbl[i].e_cred));
      chk($sformatf("tbl[%0d] in_ready", i), 128'(link.in_ready), 128'(tbl[i].e_ready));
      chk($sformatf("tbl[%0d] link_idle", i), 128'(link.link_idle), 128'(tbl[i].e_idle));
      chk($sformatf("tbl[%0d] credit_err", i), 128'(link.credit_err), 128'(tbl[i].e_err));
    end

    // Offer 12 flits with no credits returned: 8 go out, 2 park in the FIFO.
    do_reset();
    acc   = 0;
    sends = 0;
    for (int c = 0; c < 30; c++) begin
      drive(acc < 12, FW'(acc + 16), DW'(acc), 1'b1, 1'b0);
      hs = link.in_valid && link.in_ready;
      @(negedge clk);
      if (hs) acc++;
      if (link.send_out) sends++;
    end
    chk("stream accepted", 128'(acc), 128'(10));
    chk("stream sends", 128'(sends), 128'(8));
    chk("stream credits", 128'(link.credits_avail), 128'(0));
    chk("stream in_ready", 128'(link.in_ready), 128'(0));

    // One returned credit releases exactly one flit, two cycles later.
    link.credit_in = 1'b1;
    @(negedge clk);
    link.credit_in = 1'b0;
    chk("pulse send t+1", 128'(link.send_out), 128'(0));
    chk("pulse credits t+1", 128'(link.credits_avail), 128'(1));
    @(negedge clk);
    chk("pulse send t+2", 128'(link.send_out), 128'(1));
    chk("pulse credits t+2", 128'(link.credits_avail), 128'(0));
    sends = 0;
    repeat (5) begin
      @(negedge clk);
      if (link.send_out) sends++;
    end
    chk("pulse extra sends", 128'(sends), 128'(0));
    link.in_valid = 1'b0;

    // Sustained: credits returned every cycle once the first 8 are spent.
    do_reset();
    acc   = 0;
    sends = 0;
    for (int c = 0; c < 40 && sends < 8; c++) begin
      drive(1'b1, FW'(acc + 100), DW'(acc), acc[0], 1'b0);
      acc++;
      @(negedge clk);
      if (link.send_out) sends++;
    end
    chk("sustain first sends", 128'(sends), 128'(8));
    link.credit_in = 1'b1;
    repeat (3) begin
      link.in_data = FW'(acc + 100);
      acc++;
      @(negedge clk);
    end
    sends = 0;
    for (int c = 0; c < 20; c++) begin
      link.in_data = FW'(acc + 100);
      acc++;
      @(negedge clk);
      if (link.send_out) sends++;
      chk("sustain credits", 128'(link.credits_avail), 128'(1));
    end
    chk("sustain throughput", 128'(sends), 128'(20));
    chk("sustain credit_err", 128'(link.credit_err), 128'(0));
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Reset mid-packet, with a credit returned in the reset cycle.
    do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, FW'(8'h77), 6'd5, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, FW'(8'h78), 6'd7, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midpkt err before reset", 128'(link.credit_err), 128'(1));
    chk("midpkt dest held", 128'(link.dest_out), 128'(5));
    chk("midpkt idle before reset", 128'(link.link_idle), 128'(0));
    rst = 1'b1;
    drive(1'b1, FW'(8'h79), 6'd9, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst send_out", 128'(link.send_out), 128'(0));
    chk("rst data_out", 128'(link.data_out), 128'(0));
    chk("rst dest_out", 128'(link.dest_out), 128'(0));
    chk("rst is_tail_out", 128'(link.is_tail_out), 128'(0));
    chk("rst credits", 128'(link.credits_avail), 128'(Depth));
    chk("rst credit_err", 128'(link.credit_err), 128'(0));
    chk("rst in_ready", 128'(link.in_ready), 128'(1));
    chk("rst link_idle", 128'(link.link_idle), 128'(1));
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Random traffic against the queue model, with rare resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom, $urandom}, DW'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
